axi_burst_master: RTL and testbench

//  Parametrised AXI4 master bridge between a cache/DMA-style requester and the AXI interconnect.

---
 rtl/axi_burst_master_if.sv | 67 ++++++
 rtl/axi_burst_master.sv | 189 ++++++++++++++++++
 tb/tb_axi_burst_master.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_master_if.sv
// AXI4 address/data/response channels used by axi_burst_master (INCR bursts only).
// The master modport belongs to the burst master; the slave modport belongs to the interconnect side.
interface axi_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_burst_master.sv
// AXI4 burst master: runs one requester read (AR->R) or write (AW->W->B) as a single INCR burst, pulsing done.
// Optional feature macro AXI_MASTER_RESP_CHK_EN: sticky err on non-OKAY responses or rlast/beat-count mismatch.
module axi_burst_master #(
  parameter int  ADDR_W    = 32,
  parameter int  DATA_W    = 32,
  parameter int  ID_W      = 4,
  parameter int  MASTER_ID = 0,
  parameter int  MAX_BEATS = 16,
  localparam int LEN_W     = $clog2(MAX_BEATS),
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [STRB_W-1:0]  req_strb,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               rd_last,
  output logic               done,
  output logic               err,
  axi_burst_master_if.master axi
);
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] AXSIZE     = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [STRB_W-1:0] strb_reg;
  logic [LEN_W:0]    beat_cnt_reg, beat_cnt_next;
  logic [LEN_W:0]    beat_cnt_inc;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              req_fire;
  logic              beat_at_len;

  // done_reg gates req_ready so a new request lands no earlier than the cycle after the done pulse.
  assign req_ready    = (state_reg == S_IDLE) && !done_reg;
  assign req_fire     = req_valid && req_ready;
  assign beat_at_len  = (beat_cnt_reg == {1'b0, len_reg});
  assign beat_cnt_inc = (beat_cnt_reg <= {1'b0, len_reg}) ? beat_cnt_reg + (LEN_W+1)'(1) : beat_cnt_reg;

  assign axi.araddr  = addr_reg;
  assign axi.arlen   = 8'(len_reg);
  assign axi.arsize  = AXSIZE;
  assign axi.arburst = BURST_INCR;
  assign axi.arid    = ID_W'(MASTER_ID);
  assign axi.awaddr  = addr_reg;
  assign axi.awlen   = 8'(len_reg);
  assign axi.awsize  = AXSIZE;
  assign axi.awburst = BURST_INCR;
  assign axi.awid    = ID_W'(MASTER_ID);
  assign axi.wdata   = wr_data;
  assign axi.wstrb   = strb_reg;

  assign rd_data = axi.rdata;
  assign done    = done_reg;
  assign err     = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      strb_reg     <= '0;
      beat_cnt_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      if (req_fire) begin
        addr_reg <= req_addr;
        len_reg  <= req_len;
        strb_reg <= req_strb;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    done_next     = 1'b0;
    axi.arvalid   = 1'b0;
    axi.rready    = 1'b0;
    axi.awvalid   = 1'b0;
    axi.wvalid    = 1'b0;
    axi.wlast     = 1'b0;
    axi.bready    = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (req_fire) begin
          state_next = req_we ? S_AW : S_AR;
        end
      end
      S_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          state_next    = S_R;
          beat_cnt_next = '0;
        end
      end
      S_R: begin
        axi.rready = 1'b1;
        rd_valid   = axi.rvalid;
        rd_last    = axi.rvalid && axi.rlast;
        // Completion tracks rlast even when it disagrees with the requested length.
        if (axi.rvalid) begin
          beat_cnt_next = beat_cnt_inc;
          if (axi.rlast) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      S_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) begin
          state_next    = S_W;
          beat_cnt_next = '0;
        end
      end
      S_W: begin
        axi.wvalid = wr_valid;
        axi.wlast  = beat_at_len;
        wr_ready   = axi.wready;
        if (wr_valid && axi.wready) begin
          beat_cnt_next = beat_cnt_inc;
          if (beat_at_len) begin
            state_next = S_B;
          end
        end
      end
      S_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef AXI_MASTER_RESP_CHK_EN
  localparam logic [1:0] RESP_OKAY = 2'b00;

  always_comb begin
    err_next = err_reg;
    if (req_fire) begin
      err_next = 1'b0;
    end
    // A beat is flagged when rlast arrives before len, or len is reached without rlast.
    if (state_reg == S_R && axi.rvalid) begin
      if (axi.rresp != RESP_OKAY || axi.rlast != beat_at_len) begin
        err_next = 1'b1;
      end
    end
    if (state_reg == S_B && axi.bvalid && axi.bresp != RESP_OKAY) begin
      err_next = 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{axi.rresp, axi.bresp};
  assign err_next    = 1'b0;
`endif

  logic [31:0] page_end;
  assign page_end = 32'(req_addr[11:0]) + (32'(req_len) + 32'd1) * 32'(STRB_W);

  a_page_4k: assert property (@(posedge clk) disable iff (rst) req_fire |-> page_end <= 32'd4096);
  a_ar_hold: assert property (@(posedge clk) disable iff (rst) axi.arvalid && !axi.arready |=> axi.arvalid);
  a_aw_hold: assert property (@(posedge clk) disable iff (rst) axi.awvalid && !axi.awready |=> axi.awvalid);
endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: bench-side AXI slave plus scoreboard queues for read and write beats.
module tb_axi_burst_master;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 4;
  localparam int MASTER_ID = 5;
  localparam int MAX_BEATS = 16;
  localparam int LEN_W     = $clog2(MAX_BEATS);
  localparam int STRB_W    = DATA_W / 8;
`ifdef AXI_MASTER_RESP_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [STRB_W-1:0] req_strb;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_last, done, err;

  int n_pass = 0;
  int n_total = 0;
  logic [DATA_W:0] exp_rd_q[$];
  logic [DATA_W:0] exp_w_q[$];

  axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  axi_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MASTER_ID(MASTER_ID), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_strb(req_strb),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .err(err),
    .axi(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    logic [7:0] obs;
    @(negedge clk);
    #1;
    obs = {req_ready, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, done, err};
    n_total++;
    if (obs !== 8'b1000_0000) $display("FAIL reset_outputs got %b want 10000000", obs); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b1;
    axi.wready = 1'b1;
    #1;
    obs = {req_ready, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, done, err};
    n_total++;
    if (obs !== 8'b1000_0000) $display("FAIL post_reset_outputs got %b want 10000000", obs); else n_pass++;
    n_total++;
    if ({wr_ready, rd_valid} !== 2'b00) $display("FAIL idle_wr_ignored got %b want 00", {wr_ready, rd_valid}); else n_pass++;
    @(negedge clk);
    wr_valid = 1'b0;
    axi.wready = 1'b0;
    $display("reset: outputs idle");
  endtask

  task automatic run_read(input logic [ADDR_W-1:0] addr, input int len, input int ar_wait,
                          input int n_beats, input logic [1:0] rr, input logic exp_err);
    int ar_cycles;
    logic [DATA_W-1:0] d;
    logic [DATA_W:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = LEN_W'(len);
    #1;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL rd_req_ready got %b want 1", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_total++;
    if (err !== 1'b0) $display("FAIL rd_err_cleared got %b want 0", err); else n_pass++;
    n_total++;
    if (axi.araddr !== addr || axi.arlen !== 8'(len) || axi.arsize !== 3'd2 || axi.arburst !== 2'b01
        || axi.arid !== ID_W'(MASTER_ID))
      $display("FAIL ar_fields got addr=%h len=%0d size=%0d burst=%b id=%0d want addr=%h len=%0d size=2 burst=01 id=%0d",
               axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid, addr, len, MASTER_ID);
    else n_pass++;
    ar_cycles = 0;
    for (int i = 0; i <= ar_wait; i++) begin
      if (i > 0) @(negedge clk);
      axi.arready = (i == ar_wait);
      #1;
      if (axi.arvalid) ar_cycles++;
    end
    @(negedge clk);
    axi.arready = 1'b0;
    n_total++;
    if (ar_cycles !== ar_wait + 1) $display("FAIL arvalid_cycles got %0d want %0d", ar_cycles, ar_wait + 1); else n_pass++;
    for (int b = 0; b < n_beats; b++) begin
      if (b > 0) begin
        @(negedge clk);
        if (b % 2 == 1) begin
          axi.rvalid = 1'b0;
          #1;
          n_total++;
          if (rd_valid !== 1'b0) $display("FAIL rd_gap_valid got %b want 0", rd_valid); else n_pass++;
          @(negedge clk);
        end
      end
      d = DATA_W'($urandom);
      axi.rdata = d; axi.rvalid = 1'b1; axi.rlast = (b == n_beats - 1); axi.rresp = rr;
      exp_rd_q.push_back({axi.rlast, d});
      #1;
      n_total++;
      if (!rd_valid || !axi.rready || exp_rd_q.size() == 0) begin
        $display("FAIL rd_beat%0d_handshake got rd_valid=%b rready=%b want 1 1", b, rd_valid, axi.rready);
      end else begin
        e = exp_rd_q.pop_front();
        if ({rd_last, rd_data} !== e)
          $display("FAIL rd_beat%0d got last=%b data=%h want last=%b data=%h", b, rd_last, rd_data, e[DATA_W], e[DATA_W-1:0]);
        else n_pass++;
      end
    end
    @(negedge clk);
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    #1;
    n_total++;
    if ({done, err, req_ready, axi.rready} !== {1'b1, exp_err, 1'b0, 1'b0})
      $display("FAIL rd_done got done=%b err=%b req_ready=%b rready=%b want 1 %b 0 0", done, err, req_ready, axi.rready, exp_err);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({done, req_ready} !== 2'b01) $display("FAIL rd_done_pulse got done=%b req_ready=%b want 0 1", done, req_ready); else n_pass++;
    $display("read  addr=%h len=%0d beats=%0d err=%b", addr, len, n_beats, err);
  endtask

  task automatic run_write(input logic [ADDR_W-1:0] addr, input int len, input logic [STRB_W-1:0] strb,
                           input logic [DATA_W-1:0] d0, input logic toggle, input int aw_wait,
                           input logic [1:0] br, input logic exp_err);
    int aw_cycles, k, pushed, beats, lasts, cyc;
    logic [DATA_W:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_len = LEN_W'(len); req_strb = strb;
    #1;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL wr_req_ready got %b want 1", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_total++;
    if (axi.awaddr !== addr || axi.awlen !== 8'(len) || axi.awsize !== 3'd2 || axi.awburst !== 2'b01
        || axi.awid !== ID_W'(MASTER_ID) || err !== 1'b0)
      $display("FAIL aw_fields got addr=%h len=%0d size=%0d burst=%b id=%0d err=%b want addr=%h len=%0d size=2 burst=01 id=%0d err=0",
               axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid, err, addr, len, MASTER_ID);
    else n_pass++;
    aw_cycles = 0;
    for (int i = 0; i <= aw_wait; i++) begin
      if (i > 0) @(negedge clk);
      axi.awready = (i == aw_wait);
      #1;
      if (axi.awvalid) aw_cycles++;
    end
    @(negedge clk);
    axi.awready = 1'b0;
    axi.wready = 1'b1;
    n_total++;
    if (aw_cycles !== aw_wait + 1) $display("FAIL awvalid_cycles got %0d want %0d", aw_cycles, aw_wait + 1); else n_pass++;
    k = 0; pushed = -1; beats = 0; lasts = 0; cyc = 0;
    while (k <= len && cyc < 200) begin
      wr_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      wr_data = d0 + DATA_W'(k);
      if (wr_valid && pushed != k) begin
        exp_w_q.push_back({k == len, d0 + DATA_W'(k)});
        pushed = k;
      end
      #1;
      n_total++;
      if (axi.wvalid !== wr_valid) $display("FAIL wvalid_follow got %b want %b", axi.wvalid, wr_valid); else n_pass++;
      if (axi.wvalid && axi.wready) begin
        beats++;
        if (axi.wlast) lasts++;
        n_total++;
        if (exp_w_q.size() == 0) begin
          $display("FAIL w_beat%0d unexpected beat data=%h", k, axi.wdata);
        end else begin
          e = exp_w_q.pop_front();
          if ({axi.wlast, axi.wdata} !== e || axi.wstrb !== strb || wr_ready !== 1'b1)
            $display("FAIL w_beat%0d got last=%b data=%h strb=%b wr_ready=%b want last=%b data=%h strb=%b wr_ready=1",
                     k, axi.wlast, axi.wdata, axi.wstrb, wr_ready, e[DATA_W], e[DATA_W-1:0], strb);
          else n_pass++;
        end
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    axi.wready = 1'b0;
    n_total++;
    if (beats !== len + 1 || lasts !== 1)
      $display("FAIL w_beat_count got beats=%0d wlast=%0d want beats=%0d wlast=1", beats, lasts, len + 1);
    else n_pass++;
    axi.bvalid = 1'b1; axi.bresp = br;
    #1;
    n_total++;
    if ({axi.bready, axi.wvalid, done} !== 3'b100)
      $display("FAIL b_phase got bready=%b wvalid=%b done=%b want 1 0 0", axi.bready, axi.wvalid, done);
    else n_pass++;
    @(negedge clk);
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    #1;
    n_total++;
    if ({done, err, req_ready} !== {1'b1, exp_err, 1'b0})
      $display("FAIL wr_done got done=%b err=%b req_ready=%b want 1 %b 0", done, err, req_ready, exp_err);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({done, req_ready} !== 2'b01) $display("FAIL wr_done_pulse got done=%b req_ready=%b want 0 1", done, req_ready); else n_pass++;
    $display("write addr=%h len=%0d beats=%0d strb=%b err=%b", addr, len, beats, strb, err);
  endtask

  task automatic test_read;
    run_read(32'h0000_0100, 3, 1, 4, 2'b00, 1'b0);
    run_read(32'h0000_0180, 0, 0, 1, 2'b00, 1'b0);
    run_read(32'h0000_0200, 15, 3, 16, 2'b00, 1'b0);
  endtask

  task automatic test_write_single;
    run_write(32'h0000_0040, 0, 4'b0011, 32'hDEAD_BEEF, 1'b0, 0, 2'b00, 1'b0);
  endtask

  task automatic test_write_toggle;
    run_write(32'h0000_0800, 7, 4'b1111, 32'h1234_5600, 1'b1, 2, 2'b00, 1'b0);
  endtask

  task automatic test_back_to_back;
    int accepts, dones, first_done, second_acc, rbeats, cyc;
    logic [DATA_W-1:0] d;
    logic [DATA_W:0] e;
    accepts = 0; dones = 0; first_done = -1; second_acc = -1; rbeats = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0400; req_len = LEN_W'(1);
    for (cyc = 0; cyc < 60 && dones < 2; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (accepts == 2) req_valid = 1'b0;
      axi.arready = axi.arvalid;
      axi.rvalid = axi.rready;
      axi.rlast = axi.rready && (rbeats % 2 == 1);
      d = DATA_W'($urandom);
      axi.rdata = d;
      if (axi.rvalid) exp_rd_q.push_back({axi.rlast, d});
      #1;
      if (done) begin
        dones++;
        if (first_done < 0) first_done = cyc;
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL b2b_ready_during_done got %b want 0", req_ready); else n_pass++;
      end
      if (req_valid && req_ready) begin
        accepts++;
        if (accepts == 2) second_acc = cyc;
      end
      if (rd_valid) begin
        n_total++;
        if (exp_rd_q.size() == 0) begin
          $display("FAIL b2b_rd_unexpected data=%h", rd_data);
        end else begin
          e = exp_rd_q.pop_front();
          if ({rd_last, rd_data} !== e)
            $display("FAIL b2b_rd got last=%b data=%h want last=%b data=%h", rd_last, rd_data, e[DATA_W], e[DATA_W-1:0]);
          else n_pass++;
        end
      end
      if (axi.rvalid && axi.rready) rbeats++;
    end
    @(negedge clk);
    req_valid = 1'b0; axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
    n_total++;
    if (dones !== 2 || accepts !== 2 || rbeats !== 4)
      $display("FAIL b2b_counts got done=%0d accepts=%0d beats=%0d want 2 2 4", dones, accepts, rbeats);
    else n_pass++;
    n_total++;
    if (second_acc !== first_done + 1)
      $display("FAIL b2b_accept_cycle got %0d want %0d", second_acc, first_done + 1);
    else n_pass++;
    $display("b2b   two reads len=1 accepts=%0d dones=%0d", accepts, dones);
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0300; req_len = LEN_W'(3); req_strb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    axi.awready = 1'b1;
    #1;
    n_total++;
    if (axi.awvalid !== 1'b1) $display("FAIL abort_awvalid got %b want 1", axi.awvalid); else n_pass++;
    @(negedge clk);
    axi.awready = 1'b0; wr_valid = 1'b1; wr_data = 32'hAAAA_0001; axi.wready = 1'b1;
    #1;
    n_total++;
    if ({axi.wvalid, axi.wlast} !== 2'b10) $display("FAIL abort_beat1 got wvalid=%b wlast=%b want 1 0", axi.wvalid, axi.wlast); else n_pass++;
    @(negedge clk);
    wr_data = 32'hAAAA_0002;
    rst = 1'b1;
    #1;
    n_total++;
    if ({axi.wvalid, axi.awvalid, axi.bready, done, req_ready} !== 5'b00001)
      $display("FAIL abort_in_reset got wvalid=%b awvalid=%b bready=%b done=%b req_ready=%b want 0 0 0 0 1",
               axi.wvalid, axi.awvalid, axi.bready, done, req_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if ({axi.wvalid, wr_ready, req_ready} !== 3'b001)
      $display("FAIL abort_idle got wvalid=%b wr_ready=%b req_ready=%b want 0 0 1", axi.wvalid, wr_ready, req_ready);
    else n_pass++;
    wr_valid = 1'b0; axi.wready = 1'b0;
    $display("abort write len=3 at beat 2, back to idle");
    run_write(32'h0000_0300, 3, 4'b1100, 32'h5555_0000, 1'b0, 1, 2'b00, 1'b0);
  endtask

  task automatic test_resp_chk;
    run_write(32'h0000_0500, 0, 4'b1111, 32'hCAFE_0000, 1'b0, 0, 2'b10, CHK);
    run_read(32'h0000_0600, 3, 0, 2, 2'b00, CHK);
    run_read(32'h0000_0700, 0, 0, 1, 2'b10, CHK);
    run_read(32'h0000_0710, 1, 0, 2, 2'b00, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_strb = '0;
    wr_data = '0; wr_valid = 1'b0;
    axi.arready = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
    test_reset();
    test_read();
    test_write_single();
    test_write_toggle();
    test_back_to_back();
    test_reset_abort();
    test_resp_chk();
    n_total++;
    if (exp_rd_q.size() != 0 || exp_w_q.size() != 0)
      $display("FAIL scoreboard_drain got rd=%0d w=%0d want 0 0", exp_rd_q.size(), exp_w_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
